// File: rtl/tt_pkg.sv
// Shared types and width helpers for the truth-table scanner.
// Covers the FSM state encoding, the table width and the ones_count width.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic int tw(input int n_vars);
    return 1 << n_vars;
  endfunction

  // A popcount of 2**n rows needs one bit more than the row index.
  function automatic int cnt_w(input int n_vars);
    return n_vars + 1;
  endfunction

  function automatic int wait_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) + 1 : 1;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundles the scanner control, evaluator stimulus/response and result signals.
// The scanner connects through the slave modport; the driver side uses master.
interface truth_table_scanner_if #(
  parameter int N_VARS = 4
);
  localparam int TW = tt_pkg::tw(N_VARS);
  localparam int CW = tt_pkg::cnt_w(N_VARS);

  logic              start;
  logic              busy;
  logic              done;
  logic [N_VARS-1:0] dut_vector;
  logic              f_sop_in;
  logic              f_pos_in;
  logic [TW-1:0]     sop_table;
  logic [TW-1:0]     pos_table;
  logic [TW-1:0]     mismatch_mask;
  logic [CW-1:0]     ones_count;
  logic              equivalent;

  modport master (
    output start, f_sop_in, f_pos_in,
    input  busy, done, dut_vector, sop_table, pos_table, mismatch_mask,
           ones_count, equivalent
  );

  modport slave (
    input  start, f_sop_in, f_pos_in,
    output busy, done, dut_vector, sop_table, pos_table, mismatch_mask,
           ones_count, equivalent
  );
endinterface

// File: rtl/tt_settle_counter.sv
// Loadable settle-time counter; term is high once the count reaches SETTLE_CYCLES-1.
module tt_settle_counter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic term
);
  import tt_pkg::*;

  localparam int WW = wait_w(SETTLE_CYCLES);
  localparam logic [WW-1:0] LAST = WW'(SETTLE_CYCLES - 1);

  logic [WW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + WW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector, samples the SoP/PoS evaluator outputs and builds
// both truth tables, their mismatch mask and the minterm count.
module truth_table_scanner #(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  truth_table_scanner_if.slave bus
);
  import tt_pkg::*;

  localparam int TW = tw(N_VARS);
  localparam int CW = cnt_w(N_VARS);
  localparam logic [N_VARS-1:0] LAST_ROW = {N_VARS{1'b1}};

  state_e            state_q, state_d;
  logic [N_VARS-1:0] index_q, index_d;
  logic [N_VARS-1:0] vec_q, vec_d;
  logic [TW-1:0]     sop_q, sop_d;
  logic [TW-1:0]     pos_q, pos_d;
  logic [TW-1:0]     mask_q, mask_d;
  logic [CW-1:0]     ones_q, ones_d;
  logic              cnt_load, cnt_en, cnt_term;

  tt_settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    vec_d    = vec_q;
    sop_d    = sop_q;
    pos_d    = pos_q;
    mask_d   = mask_q;
    ones_d   = ones_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sop_d    = '0;
          pos_d    = '0;
          mask_d   = '0;
          ones_d   = '0;
          index_d  = '0;
          vec_d    = '0;
          cnt_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_term) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sop_d[index_q]  = bus.f_sop_in;
        pos_d[index_q]  = bus.f_pos_in;
        mask_d[index_q] = bus.f_sop_in ^ bus.f_pos_in;
        ones_d          = ones_q + CW'(bus.f_sop_in);
        // The last row leaves dut_vector parked on TW-1 rather than wrapping.
        if (index_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          index_d  = index_q + N_VARS'(1);
          vec_d    = vec_q + N_VARS'(1);
          cnt_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      vec_q   <= '0;
      sop_q   <= '0;
      pos_q   <= '0;
      mask_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      vec_q   <= vec_d;
      sop_q   <= sop_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.dut_vector    = vec_q;
  assign bus.busy          = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.sop_table     = sop_q;
  assign bus.pos_table     = pos_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.ones_count    = ones_q;
  assign bus.equivalent    = (mask_q == '0);

endmodule
